// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures fetch results with AdEL check, delay-slot flag and stall counter.
// Latency 1 cycle; stall holds all D contents, flush overrides stall and loads a bubble.
module if_id_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
   parameter logic [31:0] TEXT_END  = 32'h0000_6ffc,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      instr_f,
   input  logic [31:0]      pc_f,
   input  logic [31:0]      pc8_f,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic [31:0]      pc8_d,
   output logic             valid_d,
   output logic             bd_d,
   output logic [4:0]       exc_d,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [31:0] PC8_RESET = PC_RESET + 32'd8;
   localparam logic [4:0]  EXC_NONE  = 5'd0;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;

   // Branches (REGIMM, beq/bne/blez/bgtz), j/jal, and jr/jalr all own a delay slot.
   function automatic logic is_cti(input logic [5:0] op, input logic [5:0] fn);
      logic branch_jump;
      logic reg_jump;
      branch_jump = (op >= 6'b000001) && (op <= 6'b000111);
      reg_jump    = (op == 6'b000000) && ((fn == 6'b001000) || (fn == 6'b001001));
      return branch_jump || reg_jump;
   endfunction

   logic fetch_bad;
   logic cur_cti;

   assign fetch_bad = (pc_f[1:0] != 2'b00) || (pc_f < TEXT_BASE) || (pc_f > TEXT_END);
   assign cur_cti   = is_cti(instr_d[31:26], instr_d[5:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_d <= 32'd0;
         pc_d    <= PC_RESET;
         pc8_d   <= PC8_RESET;
         valid_d <= 1'b0;
         bd_d    <= 1'b0;
         exc_d   <= EXC_NONE;
      end else if (flush) begin
         // Bubble keeps the fetch PC so a later exception can still report an EPC.
         instr_d <= 32'd0;
         pc_d    <= pc_f;
         pc8_d   <= pc8_f;
         valid_d <= 1'b0;
         bd_d    <= 1'b0;
         exc_d   <= EXC_NONE;
      end else if (!stall) begin
         instr_d <= fetch_bad ? 32'd0 : instr_f;
         pc_d    <= pc_f;
         pc8_d   <= pc8_f;
         valid_d <= 1'b1;
         bd_d    <= cur_cti && valid_d;
         exc_d   <= fetch_bad ? EXC_ADEL : EXC_NONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: every driven cycle pushes the predicted D state, popped after the edge.
module tb_if_id_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        bd;
      logic [4:0]  exc;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic [31:0] pc8_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        bd_d;
   logic [4:0]  exc_d;
   logic [15:0] stall_cnt;

   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];
   exp_t m;

   if_id_stage #(
      .PC_RESET (32'h0000_3000),
      .TEXT_BASE(32'h0000_3000),
      .TEXT_END (32'h0000_6ffc),
      .CNT_W    (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .flush    (flush),
      .instr_f  (instr_f),
      .pc_f     (pc_f),
      .pc8_f    (pc8_f),
      .instr_d  (instr_d),
      .pc_d     (pc_d),
      .pc8_d    (pc8_d),
      .valid_d  (valid_d),
      .bd_d     (bd_d),
      .exc_d    (exc_d),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ref_cti(input logic [31:0] x);
      case (x[31:26])
         6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07: return 1'b1;
         6'o00:   return (x[5:0] == 6'o10) || (x[5:0] == 6'o11);
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t reset_state();
      exp_t r;
      r.instr = 32'h0;
      r.pc    = 32'h3000;
      r.pc8   = 32'h3008;
      r.valid = 1'b0;
      r.bd    = 1'b0;
      r.exc   = 5'd0;
      r.cnt   = 16'h0;
      return r;
   endfunction

   task automatic compare_out(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         check({tag, "_sbq_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sbq.pop_front();
      check({tag, "_instr"}, instr_d, e.instr);
      check({tag, "_pc"},    pc_d,    e.pc);
      check({tag, "_pc8"},   pc8_d,   e.pc8);
      check({tag, "_valid"}, {31'd0, valid_d}, {31'd0, e.valid});
      check({tag, "_bd"},    {31'd0, bd_d},    {31'd0, e.bd});
      check({tag, "_exc"},   {27'd0, exc_d},   {27'd0, e.exc});
      check({tag, "_cnt"},   {16'd0, stall_cnt}, {16'd0, e.cnt});
   endtask

   // Drive one cycle, predict the D state after the edge, then compare it.
   task automatic step(input string tag, input logic st, input logic fl,
                       input logic [31:0] ins, input logic [31:0] pc);
      logic bad;
      stall   = st;
      flush   = fl;
      instr_f = ins;
      pc_f    = pc;
      pc8_f   = pc + 32'd8;
      bad = (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6ffc);
      if (fl) begin
         m.instr = 32'h0;
         m.valid = 1'b0;
         m.bd    = 1'b0;
         m.exc   = 5'd0;
         m.pc    = pc;
         m.pc8   = pc + 32'd8;
      end else if (!st) begin
         m.bd    = m.valid && ref_cti(m.instr);
         m.instr = bad ? 32'h0 : ins;
         m.exc   = bad ? 5'd4 : 5'd0;
         m.valid = 1'b1;
         m.pc    = pc;
         m.pc8   = pc + 32'd8;
      end
      if (st && m.cnt != 16'hffff) m.cnt = m.cnt + 16'd1;
      sbq.push_back(m);
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   initial begin
      reset   = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      instr_f = 32'h0;
      pc_f    = 32'h0;
      pc8_f   = 32'h0;
      m       = reset_state();

      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",    pc_d, 32'h3000);
      check("rst_pc8",   pc8_d, 32'h3008);
      check("rst_valid", {31'd0, valid_d}, 32'd0);
      check("rst_cnt",   {16'd0, stall_cnt}, 32'd0);
      check("rst_instr", instr_d, 32'h0);
      reset = 1'b1;

      step("ld0", 0, 0, 32'h24080005, 32'h3000);
      check("ld0_instr_const", instr_d, 32'h24080005);
      check("ld0_valid_const", {31'd0, valid_d}, 32'd1);
      step("beq", 0, 0, 32'h10000003, 32'h3004);
      step("addu_ds", 0, 0, 32'h01094021, 32'h3008);
      check("beq_ds_bd_const", {31'd0, bd_d}, 32'd1);
      step("jr", 0, 0, 32'h03e00008, 32'h300c);
      step("ori_ds", 0, 0, 32'h34210001, 32'h3010);
      check("jr_ds_bd_const", {31'd0, bd_d}, 32'd1);
      step("lui", 0, 0, 32'h3c010001, 32'h3014);
      check("ori_next_bd_const", {31'd0, bd_d}, 32'd0);

      step("stall1", 1, 0, 32'h11111111, 32'h3018);
      step("stall2", 1, 0, 32'h22222222, 32'h301c);
      step("stall3", 1, 0, 32'h33333333, 32'h3020);
      check("stall_hold_instr", instr_d, 32'h3c010001);
      check("stall_hold_pc", pc_d, 32'h3014);
      check("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
      step("unstall", 0, 0, 32'h00851020, 32'h3018);

      step("beq2", 0, 0, 32'h10000003, 32'h301c);
      step("flush_stall", 1, 1, 32'h01094021, 32'h3010);
      check("flush_pc_const", pc_d, 32'h3010);
      check("flush_cnt_const", {16'd0, stall_cnt}, 32'd4);
      step("after_bubble", 0, 0, 32'h01094021, 32'h3010);
      check("after_bubble_bd_const", {31'd0, bd_d}, 32'd0);

      step("jal", 0, 0, 32'h0c000c00, 32'h3014);
      step("jal_ds", 0, 0, 32'h00000000, 32'h3018);
      step("jalr", 0, 0, 32'h0080f809, 32'h301c);
      step("jalr_ds", 0, 0, 32'h00000000, 32'h3020);
      step("bltz", 0, 0, 32'h04800002, 32'h3024);
      step("flush_only", 0, 1, 32'h00000000, 32'h3028);
      step("bubble_next", 0, 0, 32'h00000000, 32'h3028);

      step("adel_misal", 0, 0, 32'h24080005, 32'h3002);
      check("adel_misal_exc_const", {27'd0, exc_d}, 32'd4);
      check("adel_misal_instr_const", instr_d, 32'h0);
      check("adel_misal_valid_const", {31'd0, valid_d}, 32'd1);
      step("adel_low", 0, 0, 32'h10000003, 32'h2ffc);
      step("adel_low_next", 0, 0, 32'h24080005, 32'h3000);
      step("adel_high", 0, 0, 32'h24080005, 32'h7000);
      check("adel_high_exc_const", {27'd0, exc_d}, 32'd4);
      step("top_ok", 0, 0, 32'h24080005, 32'h6ffc);
      check("top_ok_exc_const", {27'd0, exc_d}, 32'd0);

      // Reset dropped between edges while stalled and flushing.
      stall = 1'b1;
      flush = 1'b1;
      #3;
      reset = 1'b0;
      #1;
      check("arst_instr", instr_d, 32'h0);
      check("arst_pc",    pc_d, 32'h3000);
      check("arst_pc8",   pc8_d, 32'h3008);
      check("arst_valid", {31'd0, valid_d}, 32'd0);
      check("arst_cnt",   {16'd0, stall_cnt}, 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      m = reset_state();
      sbq.delete();
      step("post_arst", 0, 0, 32'h24080005, 32'h3000);

      stall = 1'b1;
      flush = 1'b0;
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
         if (m.cnt != 16'hffff) m.cnt = m.cnt + 16'd1;
      end
      #1;
      check("sat_cnt", {16'd0, stall_cnt}, 32'h0000ffff);
      check("sat_hold_instr", instr_d, 32'h24080005);
      step("sat_more", 1, 0, 32'h0, 32'h3004);
      step("sat_release", 0, 0, 32'h34210001, 32'h3004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
